neopixel_frame_scheduler: RTL and testbench

//   Sequences a full NeoPixel (GRB, WS2812-class) frame into the single-LED encoder.
//   - Fetches 24-bit pixel words from an external pixel memory (1-cycle read latency).
//   - Generates the per-bit strobe and holds sending_data.
//   - Inserts the latch/reset gap after the last pixel.
//   - Replaces the hand-timed stimulus / MultipleLEDEncoder flat-vector approach with a start/done handshake.

---
 rtl/neopixel_pkg.sv | 24 ++
 rtl/neopixel_bit_timer.sv | 87 ++++++++
 rtl/neopixel_frame_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_neopixel_frame_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// ---------------------------------------------------------------------------
// neopixel_pkg
//   Shared constants and types for the NeoPixel frame scheduler.
//   PIXEL_W               bits per GRB pixel word
//   BIT_CYCLES_DEFAULT    clock cycles per encoded bit (61 x 20 ns = 1220 ns)
//   LATCH_CYCLES_DEFAULT  clock cycles the line is held low after a frame (25 us)
//   MAX_LEDS_DEFAULT      largest frame the scheduler will sequence
//   sched_state_t         scheduler FSM states
// ---------------------------------------------------------------------------
package neopixel_pkg;

   localparam int PIXEL_W              = 24;
   localparam int BIT_CYCLES_DEFAULT   = 61;
   localparam int LATCH_CYCLES_DEFAULT = 1250;
   localparam int MAX_LEDS_DEFAULT     = 64;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      LATCH
   } sched_state_t;

endpackage

// File: rtl/neopixel_bit_timer.sv
// ---------------------------------------------------------------------------
// neopixel_bit_timer
//   Bit-period timer for the scheduler. While enabled it counts each bit
//   period 0..BIT_CYCLES-1, pulses bit_tick_o at the start of every period
//   and advances bit_index_o (0..23, wrapping) whenever the period ends.
//   The first enabled cycle after idle only arms the timer, so the very
//   first period starts with count 0 and a tick.
//
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   en_i         run the timer this cycle
//   clr_i        synchronous clear back to the idle, disarmed state
//   running_o    timer is armed and counting
//   bit_tick_o   registered pulse at the start of each bit period
//   bit_index_o  bit currently being sent
//   count_o      position inside the current bit period
// ---------------------------------------------------------------------------
module neopixel_bit_timer
   import neopixel_pkg::*;
#(
   parameter  int BIT_CYCLES = BIT_CYCLES_DEFAULT,
   localparam int CNT_W      = $clog2(BIT_CYCLES)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   output logic             running_o,
   output logic             bit_tick_o,
   output logic [4:0]       bit_index_o,
   output logic [CNT_W-1:0] count_o
);

   logic             running_q,  running_d;
   logic             tick_q,     tick_d;
   logic [4:0]       bitIndex_q, bitIndex_d;
   logic [CNT_W-1:0] bitCount_q, bitCount_d;

   // Next-state for the period counter. Clear beats enable so the owner can
   // stop the timer in the same cycle it would otherwise advance. The tick
   // defaults low so it is a single-cycle pulse in every case.
   always_comb begin
      running_d  = running_q;
      bitCount_d = bitCount_q;
      bitIndex_d = bitIndex_q;
      tick_d     = 1'b0;
      if (clr_i) begin
         running_d  = 1'b0;
         bitCount_d = '0;
         bitIndex_d = '0;
      end else if (en_i) begin
         if (!running_q) begin
            running_d  = 1'b1;
            bitCount_d = '0;
            bitIndex_d = '0;
            tick_d     = 1'b1;
         end else if (bitCount_q == CNT_W'(BIT_CYCLES - 1)) begin
            bitCount_d = '0;
            tick_d     = 1'b1;
            bitIndex_d = (bitIndex_q == 5'(PIXEL_W - 1)) ? 5'd0 : bitIndex_q + 5'd1;
         end else begin
            bitCount_d = bitCount_q + CNT_W'(1);
         end
      end
   end

   // Timer state registers; every output comes straight from a flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         running_q  <= 1'b0;
         tick_q     <= 1'b0;
         bitIndex_q <= '0;
         bitCount_q <= '0;
      end else begin
         running_q  <= running_d;
         tick_q     <= tick_d;
         bitIndex_q <= bitIndex_d;
         bitCount_q <= bitCount_d;
      end
   end

   assign running_o   = running_q;
   assign bit_tick_o  = tick_q;
   assign bit_index_o = bitIndex_q;
   assign count_o     = bitCount_q;

endmodule

// File: rtl/neopixel_frame_scheduler.sv
// ---------------------------------------------------------------------------
// neopixel_frame_scheduler
//   Sequences one NeoPixel (GRB) frame into the single-LED encoder: fetches
//   pixel words from a 1-cycle-latency memory, presents each word for 24 bit
//   periods with a per-bit strobe, then holds the line low for the latch gap
//   and pulses done. Frames are requested with a start/done handshake.
//
//   clk_i           system clock (50 MHz)
//   rst_ni          asynchronous active-low reset
//   start_i         frame request, only looked at in IDLE
//   abort_i         end the current frame early (FETCH/SEND only)
//   num_leds_i      pixel count, captured with start_i, clamped to MAX_LEDS
//   rd_en_o         pixel memory read strobe
//   rd_addr_o       pixel index being read
//   rd_data_i       pixel word {G,R,B}, valid the cycle after rd_en_o
//   pixel_data_o    word presented to the encoder
//   bit_index_o     bit of pixel_data_o being sent (MSB first)
//   bit_tick_o      pulse at the start of every bit period
//   sending_data_o  high while pixel bits are on the line
//   busy_o          high in FETCH, SEND and LATCH
//   done_o          pulse when a frame (normal or aborted) has finished
// ---------------------------------------------------------------------------
module neopixel_frame_scheduler
   import neopixel_pkg::*;
#(
   parameter  int MAX_LEDS     = MAX_LEDS_DEFAULT,
   parameter  int BIT_CYCLES   = BIT_CYCLES_DEFAULT,
   parameter  int LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
   localparam int ADDR_W       = $clog2(MAX_LEDS)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [ADDR_W:0]    num_leds_i,
   output logic               rd_en_o,
   output logic [ADDR_W-1:0]  rd_addr_o,
   input  logic [PIXEL_W-1:0] rd_data_i,
   output logic [PIXEL_W-1:0] pixel_data_o,
   output logic [4:0]         bit_index_o,
   output logic               bit_tick_o,
   output logic               sending_data_o,
   output logic               busy_o,
   output logic               done_o
);

   localparam int CNT_W = $clog2(BIT_CYCLES);
   localparam int LAT_W = $clog2(LATCH_CYCLES);

   sched_state_t       state_q;
   logic [ADDR_W:0]    numLeds_q;
   logic [ADDR_W-1:0]  pixIndex_q;
   logic [LAT_W-1:0]   latchCount_q;
   logic               rdEn_q;
   logic [ADDR_W-1:0]  rdAddr_q;
   logic [PIXEL_W-1:0] pixel_q;
   logic               sending_q;
   logic               busy_q;
   logic               done_q;

   logic               timerRunning;
   logic               timerEn;
   logic               timerClr;
   logic [4:0]         bitIndex;
   logic [CNT_W-1:0]   bitCount;

   logic [ADDR_W:0]    pixNext;
   logic               morePixels;
   logic               lastBitEnd;
   logic               frameEnd;
   logic               leaveSend;
   logic               prefetch;

   // Frame bookkeeping. The prefetch strobe is registered, so it is decided
   // one cycle before the counter reaches BIT_CYCLES-2; the memory then
   // answers during the final cycle of bit 23 and the word is captured on
   // the wrap with no gap between pixels.
   always_comb begin
      pixNext    = {1'b0, pixIndex_q} + (ADDR_W + 1)'(1);
      morePixels = (pixNext < numLeds_q);
      lastBitEnd = timerRunning && (bitCount == CNT_W'(BIT_CYCLES - 1)) &&
                   (bitIndex == 5'(PIXEL_W - 1));
      frameEnd   = lastBitEnd && !morePixels;
      leaveSend  = (state_q == SEND) && (abort_i || frameEnd);
      prefetch   = (state_q == SEND) && !abort_i && timerRunning && morePixels &&
                   (bitCount == CNT_W'(BIT_CYCLES - 3)) &&
                   (bitIndex == 5'(PIXEL_W - 1));
      timerEn    = (state_q == SEND);
      timerClr   = leaveSend;
   end

   neopixel_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) bitTimer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (timerEn),
      .clr_i       (timerClr),
      .running_o   (timerRunning),
      .bit_tick_o  (bit_tick_o),
      .bit_index_o (bitIndex),
      .count_o     (bitCount)
   );

   // Scheduler FSM with registered outputs. rd_en and done are pulses and
   // fall back to 0 unless a branch raises them. The first SEND cycle is the
   // one where the timer is not yet running: that is when the fetched word
   // is captured and the line goes active, in step with the first bit tick.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         numLeds_q    <= '0;
         pixIndex_q   <= '0;
         latchCount_q <= '0;
         rdEn_q       <= 1'b0;
         rdAddr_q     <= '0;
         pixel_q      <= '0;
         sending_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         rdEn_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i && (num_leds_i != '0)) begin
                  numLeds_q  <= (num_leds_i > (ADDR_W + 1)'(MAX_LEDS)) ?
                                (ADDR_W + 1)'(MAX_LEDS) : num_leds_i;
                  pixIndex_q <= '0;
                  rdEn_q     <= 1'b1;
                  rdAddr_q   <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            FETCH: begin
               latchCount_q <= '0;
               state_q      <= abort_i ? LATCH : SEND;
            end
            SEND: begin
               if (leaveSend) begin
                  sending_q    <= 1'b0;
                  latchCount_q <= '0;
                  state_q      <= LATCH;
               end else begin
                  if (!timerRunning) begin
                     pixel_q   <= rd_data_i;
                     sending_q <= 1'b1;
                  end else if (lastBitEnd) begin
                     pixel_q    <= rd_data_i;
                     pixIndex_q <= pixNext[ADDR_W-1:0];
                  end
                  if (prefetch) begin
                     rdEn_q   <= 1'b1;
                     rdAddr_q <= pixNext[ADDR_W-1:0];
                  end
               end
            end
            LATCH: begin
               if (latchCount_q == LAT_W'(LATCH_CYCLES - 1)) begin
                  latchCount_q <= '0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  latchCount_q <= latchCount_q + LAT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_en_o        = rdEn_q;
   assign rd_addr_o      = rdAddr_q;
   assign pixel_data_o   = pixel_q;
   assign bit_index_o    = bitIndex;
   assign sending_data_o = sending_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_neopixel_frame_scheduler
//   Self-checking bench for the NeoPixel frame scheduler. Frames are launched
//   from a table; every launch pushes the expected read addresses, pixel
//   words and done cycle into queues that a negedge monitor pops as the DUT
//   produces reads, bit ticks and done pulses. The DUT is built with an
//   8-pixel limit so the clamped-frame case stays short.
// ---------------------------------------------------------------------------
module tb_neopixel_frame_scheduler;
   import neopixel_pkg::*;

   localparam int MAX_LEDS  = 8;
   localparam int ADDR_W    = $clog2(MAX_LEDS);
   localparam int BIT_CYC   = 61;
   localparam int PIXEL_CYC = 24 * BIT_CYC;
   localparam int LATCH_CYC = 1250;

   typedef struct {
      logic [ADDR_W:0] numLeds;
      int              expReads;
      int              expDoneLat;
   } frameVec_t;

   logic                clock;
   logic                rstN;
   logic                start;
   logic                abort;
   logic [ADDR_W:0]     numLeds;
   logic                rdEn;
   logic [ADDR_W-1:0]   rdAddr;
   logic [PIXEL_W-1:0]  rdData;
   logic [PIXEL_W-1:0]  pixelData;
   logic [4:0]          bitIndex;
   logic                bitTick;
   logic                sendingData;
   logic                busy;
   logic                done;

   logic [PIXEL_W-1:0]  mem [MAX_LEDS];
   frameVec_t           vecs [4];

   int                  addrQ[$];
   logic [PIXEL_W-1:0]  pixQ[$];
   int                  doneQ[$];

   int                  cyc = 0;
   int                  checks = 0;
   int                  errors = 0;
   int                  frameStart = 0;
   int                  lastTick = 0;
   int                  tickCount = 0;
   int                  sendCycles = 0;
   int                  doneCount = 0;
   int                  doneBefore = 0;
   logic [PIXEL_W-1:0]  curPix = '0;

   neopixel_frame_scheduler #(
      .MAX_LEDS (MAX_LEDS)
   ) dut (
      .clk_i          (clock),
      .rst_ni         (rstN),
      .start_i        (start),
      .abort_i        (abort),
      .num_leds_i     (numLeds),
      .rd_en_o        (rdEn),
      .rd_addr_o      (rdAddr),
      .rd_data_i      (rdData),
      .pixel_data_o   (pixelData),
      .bit_index_o    (bitIndex),
      .bit_tick_o     (bitTick),
      .sending_data_o (sendingData),
      .busy_o         (busy),
      .done_o         (done)
   );

   // 50 MHz clock.
   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   // Free-running cycle counter used to timestamp DUT events.
   always @(posedge clock) cyc <= cyc + 1;

   // Pixel memory with one cycle of read latency.
   always @(posedge clock) begin
      if (rdEn) rdData <= mem[rdAddr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Scoreboard monitor: pops expectations as the DUT produces reads,
   // bit ticks and done pulses. Sampling on the falling edge keeps it away
   // from the active edge.
   always @(negedge clock) begin
      if (rstN) begin
         if (rdEn) begin
            if (addrQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rd: got read of %0d, expected no read (cycle %0d)", rdAddr, cyc);
            end else begin
               checkOutput("rd_addr", 32'(rdAddr), 32'(addrQ.pop_front()));
            end
         end
         if (sendingData) sendCycles++;
         if (bitTick) begin
            checkOutput("tick_sending", 32'(sendingData), 32'd1);
            if (tickCount == 0) checkOutput("first_tick_cycle", 32'(cyc), 32'(frameStart + 2));
            else checkOutput("tick_spacing", 32'(cyc - lastTick), 32'(BIT_CYC));
            checkOutput("bit_index", 32'(bitIndex), 32'(tickCount % 24));
            if ((tickCount % 24) == 0) begin
               if (pixQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_pixel: got %0h, expected no new pixel (cycle %0d)", pixelData, cyc);
               end else begin
                  curPix = pixQ.pop_front();
               end
            end
            checkOutput("pixel_data", 32'(pixelData), 32'(curPix));
            lastTick = cyc;
            tickCount++;
         end
         if (done) begin
            doneCount++;
            checkOutput("done_busy_low", 32'(busy), 32'd0);
            if (doneQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
            end else begin
               checkOutput("done_cycle", 32'(cyc), 32'(doneQ.pop_front()));
            end
         end
      end
   end

   // Pulse start for one cycle and load the scoreboard with what the frame
   // must produce. abortToo drives abort in the same cycle as start.
   task automatic applyStimulus(input logic [ADDR_W:0] num, input int expReads,
                                input int expLat, input logic abortToo);
      @(negedge clock);
      start   = 1'b1;
      numLeds = num;
      abort   = abortToo;
      @(posedge clock);
      #1;
      start      = 1'b0;
      abort      = 1'b0;
      frameStart = cyc;
      tickCount  = 0;
      sendCycles = 0;
      doneBefore = doneCount;
      for (int i = 0; i < expReads; i++) begin
         addrQ.push_back(i);
         pixQ.push_back(mem[i]);
      end
      if (expReads > 0) doneQ.push_back(cyc + expLat);
   endtask

   task automatic waitDone(input int budget);
      int waited = 0;
      while (doneQ.size() != 0 && waited < budget) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("done_timeout", 32'(doneQ.size()), 32'd0);
      doneQ.delete();
   endtask

   task automatic checkFrameEnd(input int n);
      checkOutput("tick_count", 32'(tickCount), 32'(n * 24));
      checkOutput("send_cycles", 32'(sendCycles), 32'(n * PIXEL_CYC));
      checkOutput("reads_left", 32'(addrQ.size()), 32'd0);
      checkOutput("pixels_left", 32'(pixQ.size()), 32'd0);
      checkOutput("done_count", 32'(doneCount - doneBefore), 32'd1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_rd_en"}, 32'(rdEn), 32'd0);
      checkOutput({tag, "_rd_addr"}, 32'(rdAddr), 32'd0);
      checkOutput({tag, "_pixel"}, 32'(pixelData), 32'd0);
      checkOutput({tag, "_bit_index"}, 32'(bitIndex), 32'd0);
      checkOutput({tag, "_bit_tick"}, 32'(bitTick), 32'd0);
      checkOutput({tag, "_sending"}, 32'(sendingData), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int waited;
      int abortCyc;

      rstN    = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      numLeds = '0;
      mem[0] = 24'h00FF00;
      mem[1] = 24'hFF00FF;
      mem[2] = 24'hBDC345;
      mem[3] = 24'h1B4322;
      mem[4] = 24'h123456;
      mem[5] = 24'hABCDEF;
      mem[6] = 24'h0F0F0F;
      mem[7] = 24'h800001;

      // {num_leds, reads expected, start-to-done cycles}
      vecs[0] = '{numLeds: 4'd1,  expReads: 1, expDoneLat: 2716};
      vecs[1] = '{numLeds: 4'd4,  expReads: 4, expDoneLat: 7108};
      vecs[2] = '{numLeds: 4'd0,  expReads: 0, expDoneLat: 0};
      vecs[3] = '{numLeds: 4'd13, expReads: 8, expDoneLat: 12964};

      #5;
      checkAllZero("reset");
      repeat (3) @(negedge clock);
      rstN = 1'b1;

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].numLeds, vecs[i].expReads, vecs[i].expDoneLat, 1'b0);
         if (vecs[i].expReads == 0) begin
            repeat (30) @(negedge clock);
            checkOutput("zero_busy", 32'(busy), 32'd0);
            checkOutput("zero_done_count", 32'(doneCount - doneBefore), 32'd0);
         end else begin
            waitDone(vecs[i].expDoneLat + 100);
            checkFrameEnd(vecs[i].expReads);
         end
      end

      // A second start while busy must be dropped, not queued.
      applyStimulus(4'd2, 2, 4180, 1'b0);
      repeat (100) @(negedge clock);
      start   = 1'b1;
      numLeds = 4'd1;
      @(negedge clock);
      start = 1'b0;
      waitDone(4300);
      checkFrameEnd(2);
      repeat (50) @(negedge clock);
      checkOutput("busy_start_one_done", 32'(doneCount - doneBefore), 32'd1);
      checkOutput("busy_start_idle", 32'(busy), 32'd0);

      // Abort during pixel 2, bit 5: line drops next cycle, done after the gap.
      applyStimulus(4'd4, 4, 7108, 1'b0);
      waited = 0;
      while (tickCount < 54 && waited < 10000) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("abort_tick_wait", 32'(tickCount >= 54), 32'd1);
      repeat (10) @(negedge clock);
      abort = 1'b1;
      @(posedge clock);
      #1;
      abort    = 1'b0;
      abortCyc = cyc;
      addrQ.delete();
      pixQ.delete();
      doneQ.delete();
      doneQ.push_back(abortCyc + LATCH_CYC);
      @(negedge clock);
      checkOutput("abort_sending", 32'(sendingData), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd1);
      waitDone(LATCH_CYC + 50);
      checkOutput("abort_done_count", 32'(doneCount - doneBefore), 32'd1);

      // New frame after the abort, with abort raised alongside start: start wins.
      applyStimulus(4'd1, 1, 2716, 1'b1);
      waitDone(2816);
      checkFrameEnd(1);

      // Asynchronous reset mid-SEND, then a clean single-pixel frame.
      applyStimulus(4'd4, 4, 7108, 1'b0);
      waited = 0;
      while (tickCount < 10 && waited < 2000) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("reset_tick_wait", 32'(tickCount >= 10), 32'd1);
      @(negedge clock);
      #3;
      rstN = 1'b0;
      #1;
      checkAllZero("midreset");
      addrQ.delete();
      pixQ.delete();
      doneQ.delete();
      repeat (3) @(negedge clock);
      rstN = 1'b1;
      applyStimulus(4'd1, 1, 2716, 1'b0);
      waitDone(2816);
      checkFrameEnd(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
